// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller and the ALU-op
// decoder (also used by the single-cycle controller): opcode/funct
// constants, 5-bit ALU operation codes, FSM state encoding and datapath
// mux-select encodings.
package mc_ctrl_pkg;

  localparam int ALU_OP_BITS = 5;
  localparam int STATE_BITS  = 4;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALU operation codes
  localparam logic [ALU_OP_BITS-1:0] OP_ADD  = 5'd0;
  localparam logic [ALU_OP_BITS-1:0] OP_ADDU = 5'd1;
  localparam logic [ALU_OP_BITS-1:0] OP_SUB  = 5'd2;
  localparam logic [ALU_OP_BITS-1:0] OP_SUBU = 5'd3;
  localparam logic [ALU_OP_BITS-1:0] OP_AND  = 5'd4;
  localparam logic [ALU_OP_BITS-1:0] OP_OR   = 5'd5;
  localparam logic [ALU_OP_BITS-1:0] OP_XOR  = 5'd6;
  localparam logic [ALU_OP_BITS-1:0] OP_NOR  = 5'd7;
  localparam logic [ALU_OP_BITS-1:0] OP_SLT  = 5'd8;
  localparam logic [ALU_OP_BITS-1:0] OP_SLTU = 5'd9;
  localparam logic [ALU_OP_BITS-1:0] OP_SLL  = 5'd10;
  localparam logic [ALU_OP_BITS-1:0] OP_SRL  = 5'd11;
  localparam logic [ALU_OP_BITS-1:0] OP_SRA  = 5'd12;
  localparam logic [ALU_OP_BITS-1:0] OP_SLLV = 5'd13;
  localparam logic [ALU_OP_BITS-1:0] OP_SRLV = 5'd14;
  localparam logic [ALU_OP_BITS-1:0] OP_SRAV = 5'd15;
  localparam logic [ALU_OP_BITS-1:0] OP_LUI  = 5'd16;

  // FSM state encoding (13 of 16 codes used)
  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JR        = 4'd12
  } state_e;

  // pc_src select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REGA   = 2'b11;

  // alu_src_b select
  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // reg_dst select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // addi..lui occupy opcodes 001000..001111
  function automatic logic is_alu_imm(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational map from (opcode, funct) to the 5-bit ALU operation code.
// Ports:
//   op            in  6  primary opcode
//   fn            in  6  R-type function field
//   alu_operation out 5  ALU op; OP_ADD for anything without an ALU meaning
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]             op,
  input  logic [5:0]             fn,
  output logic [ALU_OP_BITS-1:0] alu_operation
);

  always_comb begin
    alu_operation = OP_ADD;
    case (op)
      OPC_RTYPE: begin
        case (fn)
          FN_ADD:  alu_operation = OP_ADD;
          FN_ADDU: alu_operation = OP_ADDU;
          FN_SUB:  alu_operation = OP_SUB;
          FN_SUBU: alu_operation = OP_SUBU;
          FN_AND:  alu_operation = OP_AND;
          FN_OR:   alu_operation = OP_OR;
          FN_XOR:  alu_operation = OP_XOR;
          FN_NOR:  alu_operation = OP_NOR;
          FN_SLT:  alu_operation = OP_SLT;
          FN_SLTU: alu_operation = OP_SLTU;
          FN_SLL:  alu_operation = OP_SLL;
          FN_SRL:  alu_operation = OP_SRL;
          FN_SRA:  alu_operation = OP_SRA;
          FN_SLLV: alu_operation = OP_SLLV;
          FN_SRLV: alu_operation = OP_SRLV;
          FN_SRAV: alu_operation = OP_SRAV;
          default: alu_operation = OP_ADD;
        endcase
      end
      OPC_ADDI:  alu_operation = OP_ADD;
      OPC_ADDIU: alu_operation = OP_ADDU;
      OPC_SLTI:  alu_operation = OP_SLT;
      OPC_SLTIU: alu_operation = OP_SLTU;
      OPC_ANDI:  alu_operation = OP_AND;
      OPC_ORI:   alu_operation = OP_OR;
      OPC_XORI:  alu_operation = OP_XOR;
      OPC_LUI:   alu_operation = OP_LUI;
      default:   alu_operation = OP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing controller for the multicycle MIPS datapath (shared
// instruction/data memory, IR, A/B, ALUOut, MDR). Each instruction walks
// FETCH -> DECODE -> execute/memory/write-back states; memory states stall
// on mem_ready.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   opcode, func           IR fields (valid from DECODE onward)
//   zero                   ALU zero flag (branch resolution)
//   mem_ready              memory finishes the current access this cycle
//   mem_read, mem_write    memory requests, held until mem_ready
//   iord                   address mux (0 PC, 1 ALUOut)
//   ir_write, pc_write     IR / PC load enables
//   pc_src                 PC source select
//   alu_src_a, alu_src_b   ALU operand selects
//   alu_operation          ALU op code
//   reg_write, reg_dst     register file write enable / destination select
//   mem_to_reg, data_c     write-back data selects (data_c = link PC)
//   instr_done             pulse in the final cycle of each instruction
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_operation,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic               mem_to_reg,
  output logic               data_c,
  output logic               instr_done
);

  logic [STATE_W-1:0]     state_q;
  state_e                 state_d;
  logic [5:0]             op_q;
  logic [5:0]             fn_q;
  logic [ALU_OP_BITS-1:0] dec_op;

  alu_op_decoder u_alu_op_decoder (
    .op            (op_q),
    .fn            (fn_q),
    .alu_operation (dec_op)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // IR fields are captured while in DECODE so that later states are immune
  // to IR being overwritten; these are data registers and carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) begin
      op_q <= opcode;
      fn_q <= func;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REGB;
    alu_operation = OP_ADD;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = 1'b0;
    data_c        = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end

      // Dispatch uses the live IR; branch target goes into ALUOut meanwhile.
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        if (opcode == OPC_LW || opcode == OPC_SW) begin
          state_d = S_MEM_ADDR;
        end else if (opcode == OPC_RTYPE) begin
          if (func == FN_JR || func == FN_JALR) state_d = S_JR;
          else                                  state_d = S_R_EXEC;
        end else if (is_alu_imm(opcode)) begin
          state_d = S_I_EXEC;
        end else if (opcode == OPC_BEQ || opcode == OPC_BNE) begin
          state_d = S_BRANCH;
        end else if (opcode == OPC_J || opcode == OPC_JAL) begin
          state_d = S_JUMP;
        end else begin
          // Undefined opcode retires here as a NOP.
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        if (op_q == OPC_SW) state_d = S_MEM_WRITE;
        else                state_d = S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else           state_d = S_MEM_READ;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d    = S_MEM_WRITE;
        end
      end

      S_R_EXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALUB_REGB;
        alu_operation = dec_op;
        state_d       = S_R_WB;
      end

      // ALU op held so ALU result stays stable during write-back.
      S_R_WB: begin
        reg_write     = 1'b1;
        reg_dst       = REG_DST_RD;
        alu_operation = dec_op;
        instr_done    = 1'b1;
      end

      S_I_EXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALUB_IMM;
        alu_operation = dec_op;
        state_d       = S_I_WB;
      end

      S_I_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        instr_done = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALUB_REGB;
        alu_operation = OP_SUB;
        pc_src        = PC_SRC_ALUOUT;
        pc_write      = ((op_q == OPC_BEQ) & zero) | ((op_q == OPC_BNE) & ~zero);
        instr_done    = 1'b1;
      end

      // PC already holds PC+4 from FETCH, which is the link value.
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_JUMP;
        instr_done = 1'b1;
        if (op_q == OPC_JAL) begin
          reg_write = 1'b1;
          reg_dst   = REG_DST_RA;
          data_c    = 1'b1;
        end
      end

      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_REGA;
        instr_done = 1'b1;
        if (fn_q == FN_JALR) begin
          reg_write = 1'b1;
          reg_dst   = REG_DST_RA;
          data_c    = 1'b1;
        end
      end

      default: state_d = S_FETCH;
    endcase

    // Reset silences every request and enable, including an in-flight write.
    if (rst) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = PC_SRC_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUB_REGB;
      alu_operation = OP_ADD;
      reg_write     = 1'b0;
      reg_dst       = REG_DST_RT;
      mem_to_reg    = 1'b0;
      data_c        = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected output vectors
// for each instruction class, memory stalls and reset behaviour.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       mr;
    logic       mw;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [4:0] aop;
    logic       rw;
    logic [1:0] rd;
    logic       m2r;
    logic       dc;
    logic       done;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, reg_dst;
  logic       alu_src_a, reg_write, mem_to_reg, data_c, instr_done;
  logic [4:0] alu_operation;
  outs_t      obs;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .func          (func),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_operation (alu_operation),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .data_c        (data_c),
    .instr_done    (instr_done)
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_operation, reg_write, reg_dst, mem_to_reg, data_c,
                instr_done};

  // Expected output vectors per state, written from the state table.
  function automatic outs_t e_fetch(input logic r);
    outs_t o = '0; o.mr = 1; o.asb = 2'b01; o.irw = r; o.pcw = r; return o;
  endfunction
  function automatic outs_t e_decode(input logic d);
    outs_t o = '0; o.asb = 2'b11; o.done = d; return o;
  endfunction
  function automatic outs_t e_memaddr();
    outs_t o = '0; o.asa = 1; o.asb = 2'b10; return o;
  endfunction
  function automatic outs_t e_memread();
    outs_t o = '0; o.mr = 1; o.iord = 1; return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = '0; o.rw = 1; o.m2r = 1; o.done = 1; return o;
  endfunction
  function automatic outs_t e_memwrite(input logic r);
    outs_t o = '0; o.mw = 1; o.iord = 1; o.done = r; return o;
  endfunction
  function automatic outs_t e_exec(input logic [1:0] b, input logic [4:0] a);
    outs_t o = '0; o.asa = 1; o.asb = b; o.aop = a; return o;
  endfunction
  function automatic outs_t e_wb(input logic [1:0] d, input logic [4:0] a);
    outs_t o = '0; o.rw = 1; o.rd = d; o.aop = a; o.done = 1; return o;
  endfunction
  function automatic outs_t e_branch(input logic t);
    outs_t o = '0; o.asa = 1; o.aop = 5'd2; o.pcs = 2'b01; o.pcw = t; o.done = 1; return o;
  endfunction
  function automatic outs_t e_jump(input logic [1:0] s, input logic l);
    outs_t o = '0; o.pcw = 1; o.pcs = s; o.done = 1;
    o.rw = l; o.rd = l ? 2'b10 : 2'b00; o.dc = l; return o;
  endfunction

  task automatic test_reset();
    rst = 1; mem_ready = 1; zero = 0; opcode = 6'b111111; func = 6'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== outs_t'(0)) begin
        errors++; $display("FAIL reset cyc%0d: got %h want %h", i, obs, outs_t'(0));
      end
      @(posedge clk); #2;
    end
    rst = 0;
    #1;
    checks++;
    if (obs !== e_fetch(1)) begin
      errors++; $display("FAIL reset_first_fetch: got %h want %h", obs, e_fetch(1));
    end
    @(posedge clk); #2;
    #1;
    checks++;
    if (obs !== e_decode(1)) begin
      errors++; $display("FAIL reset_nop_decode: got %h want %h", obs, e_decode(1));
    end
    @(posedge clk); #2;
  endtask

  task automatic test_lw();
    outs_t want [8]; logic rdy [8]; logic [5:0] op = 6'b100011, fn = 6'b0;
    for (int i = 0; i < 8; i++) rdy[i] = 1;
    want[0] = e_fetch(1); want[1] = e_decode(0); want[2] = e_memaddr();
    want[3] = e_memread(); want[4] = e_memread(); want[5] = e_memread();
    want[6] = e_memwb(); rdy[3] = 0; rdy[4] = 0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i]; zero = 0;
      opcode = (i >= 2) ? ~op : op; func = (i >= 2) ? ~fn : fn;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL lw cyc%0d: got %h want %h", i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_sw();
    outs_t want [8]; logic rdy [8]; logic [5:0] op = 6'b101011, fn = 6'b0;
    for (int i = 0; i < 8; i++) rdy[i] = 1;
    want[0] = e_fetch(0); rdy[0] = 0; want[1] = e_fetch(1); want[2] = e_decode(0);
    want[3] = e_memaddr(); want[4] = e_memwrite(0); rdy[4] = 0; want[5] = e_memwrite(1);
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i]; zero = 0;
      opcode = (i >= 3) ? ~op : op; func = (i >= 3) ? ~fn : fn;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL sw cyc%0d: got %h want %h", i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic taken,
                             input string nm);
    outs_t want [3];
    want[0] = e_fetch(1); want[1] = e_decode(0); want[2] = e_branch(taken);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1; zero = (i == 2) ? z : ~z; func = 6'b0;
      opcode = (i >= 2) ? ~op : op;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL %s cyc%0d: got %h want %h", nm, i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [4:0] aop, input string nm);
    outs_t want [4];
    want[0] = e_fetch(1); want[1] = e_decode(0);
    want[2] = e_exec(2'b00, aop); want[3] = e_wb(2'b01, aop);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1; zero = 0;
      opcode = (i >= 2) ? 6'b111111 : 6'b000000; func = (i >= 2) ? ~fn : fn;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL %s cyc%0d: got %h want %h", nm, i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_itype(input logic [5:0] op, input logic [4:0] aop, input string nm);
    outs_t want [4];
    want[0] = e_fetch(1); want[1] = e_decode(0);
    want[2] = e_exec(2'b10, aop); want[3] = e_wb(2'b00, 5'd0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1; zero = 0; func = 6'b100010;
      opcode = (i >= 2) ? ~op : op;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL %s cyc%0d: got %h want %h", nm, i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_jump(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] src,
                           input logic link, input string nm);
    outs_t want [3];
    want[0] = e_fetch(1); want[1] = e_decode(0); want[2] = e_jump(src, link);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1; zero = 0;
      opcode = (i >= 2) ? ~op : op; func = (i >= 2) ? ~fn : fn;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL %s cyc%0d: got %h want %h", nm, i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  // Undefined opcode retires in DECODE; third cycle shows FETCH again (held).
  task automatic test_undefined();
    outs_t want [3]; logic rdy [3];
    want[0] = e_fetch(1); rdy[0] = 1; want[1] = e_decode(1); rdy[1] = 1;
    want[2] = e_fetch(0); rdy[2] = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy[i]; zero = 0; opcode = 6'b111111; func = 6'b0;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL undefined cyc%0d: got %h want %h", i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_rst_mid_write();
    outs_t want [6]; logic rdy [6]; logic rs [6];
    want[0] = e_fetch(1); rdy[0] = 1; rs[0] = 0;
    want[1] = e_decode(0); rdy[1] = 1; rs[1] = 0;
    want[2] = e_memaddr(); rdy[2] = 1; rs[2] = 0;
    want[3] = '0;          rdy[3] = 0; rs[3] = 1;
    want[4] = e_fetch(0);  rdy[4] = 0; rs[4] = 0;
    want[5] = e_fetch(0);  rdy[5] = 0; rs[5] = 0;
    for (int i = 0; i < 6; i++) begin
      rst = rs[i]; mem_ready = rdy[i]; zero = 0; func = 6'b0;
      opcode = (i >= 2) ? 6'b010100 : 6'b101011;
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL rst_mid_write cyc%0d: got %h want %h", i + 1, obs, want[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branch(6'b000100, 1'b1, 1'b1, "beq_taken");
    test_branch(6'b000100, 1'b0, 1'b0, "beq_not_taken");
    test_branch(6'b000101, 1'b0, 1'b1, "bne_taken");
    test_branch(6'b000101, 1'b1, 1'b0, "bne_not_taken");
    test_rtype(6'b100010, 5'd2, "r_sub");
    test_rtype(6'b100101, 5'd5, "r_or");
    test_itype(6'b001101, 5'd5, "ori");
    test_itype(6'b001010, 5'd8, "slti");
    test_itype(6'b001111, 5'd16, "lui");
    test_jump(6'b000011, 6'b000000, 2'b10, 1'b1, "jal");
    test_jump(6'b000000, 6'b001001, 2'b11, 1'b1, "jalr");
    test_jump(6'b000010, 6'b000000, 2'b10, 1'b0, "j");
    test_jump(6'b000000, 6'b001000, 2'b11, 1'b0, "jr");
    test_sw();
    test_undefined();
    test_rst_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
